// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and FSM encoding for the RAM-backed FIFO controller.
// The width/depth constants also size the 32x32 RAM it drives.
package ram_fifo_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_POP_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream-side handshake and RAM strobe bundle for ram_fifo_ctrl.
// slave: the controller itself; master: whatever drives the stream side
// and sits behind the RAM pins.
interface ram_fifo_ctrl_if;
   import ram_fifo_ctrl_pkg::*;

   logic              clr;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              push_ready;
   logic              pop;
   logic              pop_ready;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              err;
   logic              m_cen;
   logic              m_wen;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_din;
   logic [DATA_W-1:0] m_dout;

   modport slave (
      input  clr, push, push_data, pop, m_dout,
      output push_ready, pop_ready, pop_data, pop_valid, full, empty, count, err,
             m_cen, m_wen, m_addr, m_din
   );

   modport master (
      output clr, push, push_data, pop, m_dout,
      input  push_ready, pop_ready, pop_data, pop_valid, full, empty, count, err,
             m_cen, m_wen, m_addr, m_din
   );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous RAM with one-cycle
// registered read data.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | ready for a pop (priority) or a push
//   ST_POP_WAIT | RAM read in flight; capture m_dout at the end of cycle
//
// A pop blocks further pops for one cycle because the single RAM port
// returns data a cycle after the strobe. Pushes may still use the port in
// ST_POP_WAIT: the RAM clears its dout on a write at the same edge that the
// read word is captured, so the capture sees the read data.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
(
   input logic            clk,
   input logic            reset_n,
   ram_fifo_ctrl_if.slave bus
);

   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              err_q;
   logic              pop_valid_q;
   logic [DATA_W-1:0] pop_data_q;

   logic              full;
   logic              empty;
   logic              push_ok;
   logic              pop_ok;
   logic              err_set;
   logic              m_cen;
   logic              m_wen;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_din;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     state <= ST_IDLE;
      else if (bus.clr) state <= ST_IDLE;
      else              state <= next_state;
   end

   // Next state, handshake acceptance and RAM strobe decode
   always_comb begin
      next_state = state;
      pop_ok     = 1'b0;
      push_ok    = 1'b0;
      err_set    = 1'b0;
      m_cen      = 1'b0;
      m_wen      = 1'b0;
      m_addr     = '0;
      m_din      = '0;
      if (!bus.clr) begin
         err_set = bus.push && full;
         case (state)
            ST_IDLE: begin
               err_set = err_set || (bus.pop && empty);
               if (bus.pop && !empty) begin
                  pop_ok     = 1'b1;
                  next_state = ST_POP_WAIT;
               end else if (bus.push && !full) begin
                  push_ok = 1'b1;
               end
            end
            ST_POP_WAIT: begin
               next_state = ST_IDLE;
               push_ok    = bus.push && !full;
            end
            default: next_state = ST_IDLE;
         endcase
         if (pop_ok) begin
            m_cen  = 1'b1;
            m_addr = rd_ptr;
         end else if (push_ok) begin
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_addr = wr_ptr;
            m_din  = bus.push_data;
         end
      end
   end

   // Pointers, occupancy, sticky error and read-data capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_q       <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
      end else if (bus.clr) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_q       <= 1'b0;
         pop_valid_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_ok)     count <= count + CNT_ONE;
         else if (pop_ok) count <= count - CNT_ONE;
         err_q       <= err_q || err_set;
         pop_valid_q <= (state == ST_POP_WAIT);
         if (state == ST_POP_WAIT) pop_data_q <= bus.m_dout;
      end
   end

   assign bus.push_ready = push_ok;
   assign bus.pop_ready  = pop_ok;
   assign bus.pop_data   = pop_data_q;
   assign bus.pop_valid  = pop_valid_q;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.count      = count;
   assign bus.err        = err_q;
   assign bus.m_cen      = m_cen;
   assign bus.m_wen      = m_wen;
   assign bus.m_addr     = m_addr;
   assign bus.m_din      = m_din;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a 32x32 registered-read RAM model behind the
// strobes, and a queue-based FIFO model predicting every handshake, strobe,
// flag and popped word.
module tb_ram_fifo_ctrl;
   import ram_fifo_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset_n;

   ram_fifo_ctrl_if bus();

   ram_fifo_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // RAM: one-cycle registered read, dout cleared on a write cycle
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_dout = '0;
   always @(posedge clk) begin
      if (bus.m_cen) begin
         if (bus.m_wen) begin
            mem[bus.m_addr] <= bus.m_din;
            ram_dout        <= '0;
         end else begin
            ram_dout <= mem[bus.m_addr];
         end
      end
   end
   assign bus.m_dout = ram_dout;

   // Reference model state
   logic [31:0] q[$];
   int          wr_idx;
   int          rd_idx;
   bit          m_err;
   bit          m_wait;
   logic [31:0] m_pend;
   logic [31:0] m_pop_data;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      wr_idx     = 0;
      rd_idx     = 0;
      m_err      = 1'b0;
      m_wait     = 1'b0;
      m_pend     = '0;
      m_pop_data = '0;
   endtask

   // One clock cycle, entered and left at posedge+1
   task automatic cycle(input bit p, input logic [31:0] d, input bit o, input bit c);
      bit pop_ok;
      bit push_ok;
      bit was_wait;
      int exp_addr;
      bus.push      = p;
      bus.push_data = d;
      bus.pop       = o;
      bus.clr       = c;
      #3;
      pop_ok   = !c && !m_wait && o && (q.size() > 0);
      push_ok  = !c && !pop_ok && p && (q.size() < DEPTH);
      exp_addr = pop_ok ? (rd_idx % DEPTH) : push_ok ? (wr_idx % DEPTH) : 0;
      chk("pop_ready",  32'(bus.pop_ready),  32'(pop_ok));
      chk("push_ready", 32'(bus.push_ready), 32'(push_ok));
      chk("m_cen",      32'(bus.m_cen),      32'(pop_ok || push_ok));
      chk("m_wen",      32'(bus.m_wen),      32'(push_ok));
      chk("m_addr",     32'(bus.m_addr),     32'(exp_addr));
      chk("m_din",      bus.m_din,           push_ok ? d : 32'h0);
      chk("count",      32'(bus.count),      32'(q.size()));
      chk("empty",      32'(bus.empty),      32'(q.size() == 0));
      chk("full",       32'(bus.full),       32'(q.size() == DEPTH));
      chk("err",        32'(bus.err),        32'(m_err));
      @(posedge clk);
      #1;
      was_wait = m_wait;
      if (c) begin
         q.delete();
         wr_idx = 0;
         rd_idx = 0;
         m_err  = 1'b0;
         m_wait = 1'b0;
      end else begin
         if ((p && q.size() == DEPTH) || (o && !m_wait && q.size() == 0)) m_err = 1'b1;
         if (was_wait) m_pop_data = m_pend;
         if (pop_ok) begin
            m_pend = q.pop_front();
            rd_idx++;
         end
         if (push_ok) begin
            q.push_back(d);
            wr_idx++;
         end
         m_wait = pop_ok;
      end
      chk("pop_valid", 32'(bus.pop_valid), 32'(was_wait && !c));
      chk("pop_data",  bus.pop_data,       m_pop_data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_empty"},     32'(bus.empty),     32'd1);
      chk({tag, "_full"},      32'(bus.full),      32'd0);
      chk({tag, "_count"},     32'(bus.count),     32'd0);
      chk({tag, "_err"},       32'(bus.err),       32'd0);
      chk({tag, "_pop_valid"}, 32'(bus.pop_valid), 32'd0);
      chk({tag, "_pop_data"},  bus.pop_data,       32'h0);
      chk({tag, "_m_cen"},     32'(bus.m_cen),     32'd0);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.clr       = 1'b0;
      bus.push      = 1'b0;
      bus.push_data = '0;
      bus.pop       = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // ordering: three pushes then pop held high
      cycle(1'b1, 32'hA5A50001, 1'b0, 1'b0);
      cycle(1'b1, 32'hA5A50002, 1'b0, 1'b0);
      cycle(1'b1, 32'hA5A50003, 1'b0, 1'b0);
      idle(1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      idle(2);
      chk("order_last_word", bus.pop_data, 32'hA5A50003);

      // underflow
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      idle(2);
      chk("underflow_err", 32'(bus.err), 32'd1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // fill, overflow, then wrap write to address 0
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
      chk("fill_full",  32'(bus.full),  32'd1);
      chk("fill_count", 32'(bus.count), 32'd32);
      cycle(1'b1, 32'hDEAD0033, 1'b0, 1'b0);
      chk("overflow_err", 32'(bus.err), 32'd1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      idle(1);
      cycle(1'b1, 32'hC0DE0000, 1'b0, 1'b0);
      for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_last_word", bus.pop_data, 32'hC0DE0000);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // simultaneous push+pop at count 2
      cycle(1'b1, 32'h11110001, 1'b0, 1'b0);
      cycle(1'b1, 32'h11110002, 1'b0, 1'b0);
      cycle(1'b1, 32'h11110003, 1'b1, 1'b0);
      cycle(1'b1, 32'h11110003, 1'b1, 1'b0);
      chk("simul_word", bus.pop_data, 32'h11110001);
      chk("simul_count", 32'(bus.count), 32'd2);
      idle(1);

      // flush while a read is in flight
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h22220001, 1'b0, 1'b0);
      idle(2);

      // randomized traffic with shifting push/pop bias and rare flushes
      for (int i = 0; i < 800; i++) begin
         int bias;
         bias = 20 + 20 * ((i / 100) % 4);
         cycle($urandom_range(0, 99) < bias, $urandom,
               $urandom_range(0, 99) < (100 - bias),
               $urandom_range(0, 199) == 0);
      end

      // asynchronous reset mid-cycle with data in flight
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("areset");
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      @(posedge clk);
      #1;
      chk("areset_no_pulse", 32'(bus.pop_valid), 32'd0);
      reset_n = 1'b1;
      cycle(1'b1, 32'h33330001, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("post_reset_word", bus.pop_data, 32'h33330001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
